// File: rtl/bcd_pkg.sv
// bcd_pkg: shared widths, FSM encoding and per-nibble add-3 helper for the BCD display controller
package bcd_pkg;
  localparam int BIN_W = 9;
  localparam int NUM_DIGITS = 3;
  localparam int BCD_W = 4;
  localparam int ACC_W = NUM_DIGITS * BCD_W;
  localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] v);
    logic [ACC_W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++)
      r[i*BCD_W +: BCD_W] = (v[i*BCD_W +: BCD_W] >= 4'd5) ? v[i*BCD_W +: BCD_W] + 4'd3 : v[i*BCD_W +: BCD_W];
    return r;
  endfunction
endpackage

// File: rtl/bcd_display_ctrl_if.sv
// bcd_display_ctrl_if: load/busy/done handshake plus multiplexed digit bus
interface bcd_display_ctrl_if;
  import bcd_pkg::*;
  logic [BIN_W-1:0] bin_in;
  logic load;
  logic busy;
  logic done;
  logic [BCD_W-1:0] bcd_digit;
  logic [1:0] digit_sel;
  logic [NUM_DIGITS-1:0] an;
  modport master (output bin_in, load, input busy, done, bcd_digit, digit_sel, an);
  modport slave (input bin_in, load, output busy, done, bcd_digit, digit_sel, an);
endinterface

// File: rtl/bcd_display_ctrl_display_scan.sv
// display_scan: refresh scheduler, leading-zero blanking and registered digit/enable outputs
module display_scan import bcd_pkg::*; #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ACC_W-1:0]      i_disp,
  output logic [1:0]            o_digit_sel,
  output logic [NUM_DIGITS-1:0] o_an,
  output logic [BCD_W-1:0]      o_bcd_digit
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] r_cnt;
  logic [1:0] r_sel;
  logic [NUM_DIGITS-1:0] r_an;
  logic [BCD_W-1:0] r_bcd, w_h, w_t, w_o, w_nib;
  logic w_wrap, w_blank;
  assign w_h = i_disp[11:8];
  assign w_t = i_disp[7:4];
  assign w_o = i_disp[3:0];
  assign w_wrap = r_cnt == CW'(REFRESH_DIV - 1);
  assign w_nib = (r_sel == 2'd2) ? w_h : (r_sel == 2'd1) ? w_t : w_o;
  assign w_blank = BLANK_LEADING && ((r_sel == 2'd2) ? (w_h == 4'd0) : (r_sel == 2'd1) ? (w_h == 4'd0 && w_t == 4'd0) : 1'b0);
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
      r_sel <= 2'd0;
      r_an <= 3'b110;
      r_bcd <= '0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
      if (w_wrap) r_sel <= (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
      r_an <= w_blank ? 3'b111 : ~(3'b001 << r_sel);
      r_bcd <= w_blank ? BLANK_CODE : w_nib;
    end
  end
  assign o_digit_sel = r_sel;
  assign o_an = r_an;
  assign o_bcd_digit = r_bcd;
endmodule

// File: rtl/bcd_display_ctrl.sv
// bcd_display_ctrl: serial double-dabble conversion with load/busy/done handshake feeding a digit scanner
module bcd_display_ctrl import bcd_pkg::*; #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LEADING = 1
) (
  input logic clk,
  input logic rst,
  bcd_display_ctrl_if.slave bus
);
  state_t r_state, w_next;
  logic [BIN_W-1:0] r_bin;
  logic [ACC_W-1:0] r_acc, r_disp, w_adj;
  logic [3:0] r_step;
  logic r_done, w_busy;
  assign w_adj = add3(r_acc);
  always_comb begin
    w_next = IDLE;
    w_busy = 1'b0;
    w_next = (r_state == IDLE) ? (bus.load ? SHIFT : IDLE) :
             (r_state == SHIFT) ? ((r_step == 4'(BIN_W - 1)) ? DONE : SHIFT) : IDLE;
    w_busy = r_state == SHIFT;
  end
  // done is registered so it rises in the same cycle the new digits reach the display regs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_bin <= '0;
      r_acc <= '0;
      r_step <= '0;
      r_disp <= '0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done <= r_state == DONE;
      if (r_state == IDLE && bus.load) begin
        r_bin <= bus.bin_in;
        r_acc <= '0;
        r_step <= '0;
      end
      if (r_state == SHIFT) begin
        {r_acc, r_bin} <= {w_adj[ACC_W-2:0], r_bin, 1'b0};
        r_step <= r_step + 4'd1;
      end
      if (r_state == DONE) r_disp <= r_acc;
    end
  end
  assign bus.busy = w_busy;
  assign bus.done = r_done;
  display_scan #(.REFRESH_DIV(REFRESH_DIV), .BLANK_LEADING(BLANK_LEADING)) u_scan (
    .clk(clk),
    .rst(rst),
    .i_disp(r_disp),
    .o_digit_sel(bus.digit_sel),
    .o_an(bus.an),
    .o_bcd_digit(bus.bcd_digit)
  );
endmodule

// File: tb/tb_bcd_display_ctrl.sv
// tb_bcd_display_ctrl: directed scoreboard bench, one DUT with leading-zero blanking and one without
module tb_bcd_display_ctrl;
  import bcd_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  bcd_display_ctrl_if b0();
  bcd_display_ctrl_if b1();
  assign b1.bin_in = b0.bin_in;
  assign b1.load = b0.load;
  bcd_display_ctrl #(.REFRESH_DIV(4), .BLANK_LEADING(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  bcd_display_ctrl #(.REFRESH_DIV(4), .BLANK_LEADING(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
  typedef struct {logic [3:0] h; logic [3:0] t; logic [3:0] o;} exp_t;
  exp_t q[$];
  exp_t cur, zero;
  int total = 0, passes = 0, cyc = 0, n_done = 0;
  int c_load, t1, t2, n, nd;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    n_done <= n_done + int'(b0.done);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  function automatic exp_t model(input int v);
    exp_t m;
    m.h = 4'(v / 100);
    m.t = 4'((v / 10) % 10);
    m.o = 4'(v % 10);
    return m;
  endfunction
  function automatic logic [1:0] sel_of(input int d);
    return d == 0 ? b0.digit_sel : b1.digit_sel;
  endfunction
  function automatic logic [2:0] an_of(input int d);
    return d == 0 ? b0.an : b1.an;
  endfunction
  function automatic logic [3:0] dig_of(input int d);
    return d == 0 ? b0.bcd_digit : b1.bcd_digit;
  endfunction
  task automatic start(input int v);
    b0.bin_in = 9'(v);
    b0.load = 1'b1;
    q.push_back(model(v));
    @(negedge clk);
    b0.load = 1'b0;
    c_load = cyc;
  endtask
  task automatic count_busy(output int nb);
    nb = 0;
    while (b0.busy && nb < 20) begin
      nb++;
      @(negedge clk);
    end
  endtask
  task automatic wait_done(output int at);
    int k;
    k = 0;
    while (!b0.done && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 32'(b0.done), 1);
    chk("sb_nonempty", 32'(q.size() > 0), 1);
    at = cyc;
    if (q.size() > 0) cur = q.pop_front();
  endtask
  task automatic scan(input int d, input exp_t e, input bit blank);
    for (int k = 0; k < 3; k++) begin
      int w;
      logic [3:0] dig;
      logic [2:0] ea;
      bit bl;
      w = 0;
      dig = (k == 2) ? e.h : (k == 1) ? e.t : e.o;
      bl = blank && ((k == 2) ? (e.h == 0) : (k == 1) ? (e.h == 0 && e.t == 0) : 1'b0);
      ea = bl ? 3'b111 : ~(3'b001 << k);
      while (sel_of(d) != 2'(k) && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("u%0d_sel_reach%0d", d, k), 32'(sel_of(d)), 32'(k));
      @(negedge clk);
      chk($sformatf("u%0d_an%0d", d, k), 32'(an_of(d)), 32'(ea));
      chk($sformatf("u%0d_digit%0d", d, k), 32'(dig_of(d)), bl ? 32'hF : 32'(dig));
    end
  endtask
  initial begin
    zero = model(0);
    b0.bin_in = '0;
    b0.load = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(b0.busy), 0);
    chk("rst_done", 32'(b0.done), 0);
    chk("rst_sel", 32'(b0.digit_sel), 0);
    chk("rst_an", 32'(b0.an), 32'b110);
    chk("rst_digit", 32'(b0.bcd_digit), 0);
    rst = 1'b1;
    @(negedge clk);
    start(471);
    count_busy(n);
    chk("busy_cycles_471", n, 9);
    wait_done(t1);
    chk("done_latency_471", t1 - c_load, 10);
    @(negedge clk);
    chk("done_one_cycle", 32'(b0.done), 0);
    scan(0, cur, 1'b1);
    n = 0;
    t2 = int'(b0.digit_sel);
    while (int'(b0.digit_sel) == t2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    t2 = int'(b0.digit_sel);
    n = 0;
    while (int'(b0.digit_sel) == t2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("digit_period", n, 4);
    start(510);
    count_busy(n);
    wait_done(t1);
    scan(0, cur, 1'b1);
    b0.bin_in = 9'd510;
    b0.load = 1'b1;
    q.push_back(model(510));
    @(negedge clk);
    wait_done(t1);
    b0.bin_in = 9'd511;
    q.push_back(model(511));
    @(negedge clk);
    b0.load = 1'b0;
    wait_done(t2);
    chk("b2b_gap", t2 - t1, 11);
    scan(0, cur, 1'b1);
    start(7);
    count_busy(n);
    wait_done(t1);
    scan(0, cur, 1'b1);
    scan(1, cur, 1'b0);
    start(100);
    repeat (2) @(negedge clk);
    b0.bin_in = 9'd255;
    b0.load = 1'b1;
    @(negedge clk);
    b0.load = 1'b0;
    chk("busy_during_ignored_load", 32'(b0.busy), 1);
    nd = n_done;
    wait_done(t1);
    repeat (15) @(negedge clk);
    chk("single_done_100", n_done - nd, 1);
    chk("sb_drained", q.size(), 0);
    scan(0, cur, 1'b1);
    start(471);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    q.delete();
    chk("abort_busy", 32'(b0.busy), 0);
    chk("abort_an", 32'(b0.an), 32'b110);
    chk("abort_digit", 32'(b0.bcd_digit), 0);
    chk("abort_sel", 32'(b0.digit_sel), 0);
    rst = 1'b1;
    nd = n_done;
    repeat (20) @(negedge clk);
    chk("abort_no_done", n_done - nd, 0);
    scan(0, zero, 1'b1);
    scan(1, zero, 1'b0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
